// File: rtl/free_list.sv
// Circular free list of physical register indices feeding rename.
// Allocates up to SS registers per cycle, reclaims committed old mappings, rewinds to the retire head on flush.
module free_list #(
    parameter int unsigned SS     = 2,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SS-1:0]             alloc_req,
    input  logic                      alloc_fire,
    output logic                      alloc_ready,
    output logic [SS-1:0][PREG_W-1:0] alloc_preg,
    input  logic [SS-1:0]             commit_valid,
    input  logic [SS-1:0][PREG_W-1:0] commit_old_preg,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PREG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  rhead_q, rhead_d;
    logic [PTR_W-1:0]  alloc_cnt;
    logic [PTR_W-1:0]  free_cnt;
    logic [IDX_W-1:0]  rd_idx [SS];
    logic [IDX_W-1:0]  wr_idx [SS];

    // Lanes are packed: each lane's offset is the number of active lanes below it.
    always_comb begin
        alloc_cnt = '0;
        free_cnt  = '0;
        for (int unsigned i = 0; i < SS; i++) begin
            rd_idx[i] = IDX_W'(head_q + alloc_cnt);
            wr_idx[i] = IDX_W'(tail_q + free_cnt);
            alloc_cnt = alloc_cnt + PTR_W'(alloc_req[i]);
            free_cnt  = free_cnt + PTR_W'(commit_valid[i]);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < SS; i++) begin
            alloc_preg[i] = mem_q[rd_idx[i]];
        end
    end

    assign count       = tail_q - head_q;
    assign alloc_ready = (count >= alloc_cnt);

    // Flush rewinds head to the post-commit retire head, dropping any same-cycle allocation.
    always_comb begin
        tail_d  = tail_q + free_cnt;
        rhead_d = rhead_q + free_cnt;
        head_d  = head_q;
        if (flush) begin
            head_d = rhead_d;
        end else if (alloc_fire && alloc_ready) begin
            head_d = head_q + alloc_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            rhead_q <= '0;
            tail_q  <= PTR_W'(DEPTH);
        end else begin
            head_q  <= head_d;
            rhead_q <= rhead_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_W'(DEPTH + i);
            end
        end else begin
            for (int unsigned i = 0; i < SS; i++) begin
                if (commit_valid[i]) begin
                    mem_q[wr_idx[i]] <= commit_old_preg[i];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= PTR_W'(DEPTH))
                else $error("free_list: count %0d exceeds DEPTH", count);
            assert ((head_q - rhead_q) <= PTR_W'(DEPTH))
                else $error("free_list: retire head passed allocation head");
            assert (!(alloc_fire && !alloc_ready))
                else $error("free_list: alloc_fire while not ready");
            for (int unsigned i = 0; i < SS; i++) begin
                assert (!(commit_valid[i] && commit_old_preg[i] == '0))
                    else $error("free_list: freeing p0 on lane %0d", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: queue-level model checked every cycle plus directed literal expectations.
module tb_free_list;
    logic            clk;
    logic            rst;
    logic [1:0]      alloc_req;
    logic            alloc_fire;
    logic            alloc_ready;
    logic [1:0][5:0] alloc_preg;
    logic [1:0]      commit_valid;
    logic [1:0][5:0] commit_old_preg;
    logic            flush;
    logic [5:0]      count;

    int checks = 0;
    int errors = 0;

    // Model: registers available in allocation order, and allocated-but-uncommitted in age order.
    int  fq[$];
    int  inf[$];
    bit  mvalid = 0;

    free_list #(.SS(2), .PREG_W(6), .DEPTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_fire      (alloc_fire),
        .alloc_ready     (alloc_ready),
        .alloc_preg      (alloc_preg),
        .commit_valid    (commit_valid),
        .commit_old_preg (commit_old_preg),
        .flush           (flush),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        int k;
        if (rst) begin
            fq.delete();
            inf.delete();
            for (int i = 0; i < 32; i++) fq.push_back(32 + i);
            mvalid = 1;
        end else if (mvalid) begin
            chk("model_count", 32'(count), 32'(fq.size()));
            k = 0;
            for (int i = 0; i < 2; i++) if (alloc_req[i]) k++;
            chk("model_ready", 32'(alloc_ready), 32'(fq.size() >= k));
            k = 0;
            for (int i = 0; i < 2; i++) begin
                if (alloc_req[i]) begin
                    if (k < fq.size())
                        chk($sformatf("model_preg%0d", i), 32'(alloc_preg[i]), 32'(fq[k]));
                    k++;
                end
            end
            if (alloc_fire && !flush && fq.size() >= k)
                repeat (k) inf.push_back(fq.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (commit_valid[i]) begin
                    if (inf.size() > 0) void'(inf.pop_front());
                    fq.push_back(int'(commit_old_preg[i]));
                end
            end
            if (flush) begin
                fq = {inf, fq};
                inf.delete();
            end
        end
    end

    task automatic setin(input logic [1:0] req, input logic fire, input logic [1:0] cv,
                         input int c0, input int c1, input logic fl);
        @(posedge clk);
        #1;
        alloc_req          = req;
        alloc_fire         = fire;
        commit_valid       = cv;
        commit_old_preg[0] = 6'(c0);
        commit_old_preg[1] = 6'(c1);
        flush              = fl;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        alloc_req    = '0;
        alloc_fire   = 1'b0;
        commit_valid = '0;
        flush        = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        alloc_req       = '0;
        alloc_fire      = 1'b0;
        commit_valid    = '0;
        commit_old_preg = '0;
        flush           = 1'b0;

        // Reset image
        do_reset();
        setin(2'b11, 0, 2'b00, 0, 0, 0);
        chk("rst_count", 32'(count), 32);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_preg0", 32'(alloc_preg[0]), 32);
        chk("rst_preg1", 32'(alloc_preg[1]), 33);

        // Drain to empty
        for (int c = 0; c < 16; c++) begin
            setin(2'b11, 1, 2'b00, 0, 0, 0);
            chk("drain_preg0", 32'(alloc_preg[0]), 32'(32 + 2 * c));
            chk("drain_preg1", 32'(alloc_preg[1]), 32'(33 + 2 * c));
        end
        setin(2'b11, 0, 2'b00, 0, 0, 0);
        chk("empty_count", 32'(count), 0);
        chk("empty_ready2", 32'(alloc_ready), 0);
        setin(2'b10, 0, 2'b00, 0, 0, 0);
        chk("empty_ready1", 32'(alloc_ready), 0);

        // Lane packing and wrap-around
        do_reset();
        setin(2'b10, 1, 2'b00, 0, 0, 0);
        chk("pack_preg1", 32'(alloc_preg[1]), 32);
        setin(2'b00, 0, 2'b00, 0, 0, 0);
        chk("pack_count", 32'(count), 31);
        for (int c = 0; c < 15; c++) setin(2'b11, 1, 2'b00, 0, 0, 0);
        setin(2'b01, 1, 2'b00, 0, 0, 0);
        chk("pack_last", 32'(alloc_preg[0]), 63);
        setin(2'b00, 0, 2'b11, 5, 7, 0);
        setin(2'b11, 1, 2'b00, 0, 0, 0);
        chk("wrap_preg0", 32'(alloc_preg[0]), 5);
        chk("wrap_preg1", 32'(alloc_preg[1]), 7);
        setin(2'b00, 0, 2'b00, 0, 0, 0);
        chk("wrap_count", 32'(count), 0);

        // Flush recovery
        do_reset();
        for (int c = 0; c < 3; c++) setin(2'b11, 1, 2'b00, 0, 0, 0);
        setin(2'b00, 0, 2'b00, 0, 0, 0);
        chk("fl_count26", 32'(count), 26);
        setin(2'b00, 0, 2'b11, 3, 4, 0);
        setin(2'b00, 0, 2'b00, 0, 0, 0);
        chk("fl_count28", 32'(count), 28);
        setin(2'b00, 0, 2'b00, 0, 0, 1);
        setin(2'b11, 0, 2'b00, 0, 0, 0);
        chk("fl_count32", 32'(count), 32);
        chk("fl_preg0", 32'(alloc_preg[0]), 34);
        chk("fl_preg1", 32'(alloc_preg[1]), 35);
        for (int c = 0; c < 16; c++) setin(2'b11, 1, 2'b00, 0, 0, 0);
        chk("fl_late0", 32'(alloc_preg[0]), 3);
        chk("fl_late1", 32'(alloc_preg[1]), 4);

        // Simultaneous allocate and free
        do_reset();
        for (int c = 0; c < 15; c++) setin(2'b11, 1, 2'b00, 0, 0, 0);
        setin(2'b00, 0, 2'b00, 0, 0, 0);
        chk("sim_count2", 32'(count), 2);
        setin(2'b11, 1, 2'b11, 9, 10, 0);
        chk("sim_old0", 32'(alloc_preg[0]), 62);
        chk("sim_old1", 32'(alloc_preg[1]), 63);
        setin(2'b11, 0, 2'b00, 0, 0, 0);
        chk("sim_keep2", 32'(count), 2);
        chk("sim_new0", 32'(alloc_preg[0]), 9);
        chk("sim_new1", 32'(alloc_preg[1]), 10);
        setin(2'b01, 1, 2'b00, 0, 0, 0);
        setin(2'b11, 0, 2'b01, 11, 0, 0);
        chk("sim_count1", 32'(count), 1);
        chk("sim_nobypass", 32'(alloc_ready), 0);

        // Flush with same-cycle commit
        setin(2'b00, 0, 2'b01, 12, 0, 1);
        setin(2'b11, 0, 2'b00, 0, 0, 0);
        chk("flc_count", 32'(count), 32);
        chk("flc_preg0", 32'(alloc_preg[0]), 36);
        chk("flc_preg1", 32'(alloc_preg[1]), 37);

        // Reset mid-drain
        do_reset();
        for (int c = 0; c < 3; c++) setin(2'b11, 1, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        alloc_fire = 1'b0;
        alloc_req  = 2'b11;
        #1;
        chk("mid_count", 32'(count), 32);
        chk("mid_preg0", 32'(alloc_preg[0]), 32);
        chk("mid_preg1", 32'(alloc_preg[1]), 33);
        setin(2'b00, 0, 2'b00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
